// File: rtl/seq_pattern_gen_if.sv
// Serial pattern generator bus: control/pattern request from the master,
// serial stream and progress flags back from the generator.
interface seq_pattern_gen_if #(
    parameter int PAT_W = 10,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic             abort;
    logic             use_def;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             x;
    logic             valid;
    logic             sof;
    logic             eof;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, use_def, pattern, reps, gap,
        input  x, valid, sof, eof, busy, done
    );

    modport slave (
        input  start, abort, use_def, pattern, reps, gap,
        output x, valid, sof, eof, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first with
// repeat count and inter-frame gap; all outputs registered.
module seq_pattern_gen #(
    parameter int               PAT_W   = 10,
    parameter logic [PAT_W-1:0] DEF_PAT = 10'b1011101010,
    parameter int               CNT_W   = 4,
    parameter int               GAP_W   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    seq_pattern_gen_if.slave  bus
);
    localparam int IW = $clog2(PAT_W);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    typedef struct packed {
        logic x;
        logic valid;
        logic sof;
        logic eof;
        logic busy;
        logic done;
    } out_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] sh, sh_n, pat, pat_n, load_pat, sel;
    logic [IW-1:0]    idx, idx_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [GAP_W-1:0] g, g_n, gcnt, gcnt_n;
    logic             load;
    out_t             o, o_n;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            sh    <= '0;
            pat   <= '0;
            idx   <= '0;
            rem   <= '0;
            g     <= '0;
            gcnt  <= '0;
            o     <= '0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            pat   <= pat_n;
            idx   <= idx_n;
            rem   <= rem_n;
            g     <= g_n;
            gcnt  <= gcnt_n;
            o     <= o_n;
        end
    end

    // o_n is what the outputs show during the cycle after this edge.
    always_comb begin
        state_n  = state;
        sh_n     = sh;
        pat_n    = pat;
        idx_n    = idx;
        rem_n    = rem;
        g_n      = g;
        gcnt_n   = gcnt;
        o_n      = '0;
        load     = 1'b0;
        load_pat = pat;
        sel      = bus.use_def ? DEF_PAT : bus.pattern;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    pat_n    = sel;
                    rem_n    = (bus.reps == '0) ? CNT_W'(1) : bus.reps;
                    g_n      = bus.gap;
                    load     = 1'b1;
                    load_pat = sel;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_n  = FIN;
                    o_n.done = 1'b1;
                end else if (idx == '0) begin
                    rem_n = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state_n  = FIN;
                        o_n.done = 1'b1;
                    end else if (g != '0) begin
                        state_n  = GAP;
                        gcnt_n   = g;
                        o_n.busy = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end else begin
                    sh_n      = {sh[PAT_W-2:0], 1'b0};
                    idx_n     = idx - IW'(1);
                    o_n.x     = sh[PAT_W-2];
                    o_n.valid = 1'b1;
                    o_n.busy  = 1'b1;
                    o_n.eof   = (idx == IW'(1));
                end
            end
            GAP: begin
                gcnt_n = gcnt - GAP_W'(1);
                if (bus.abort) begin
                    state_n  = FIN;
                    o_n.done = 1'b1;
                end else if (gcnt == GAP_W'(1)) begin
                    load = 1'b1;
                end else begin
                    o_n.busy = 1'b1;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Frame start: reload the shift register and present the MSB.
        if (load) begin
            state_n   = SEND;
            sh_n      = load_pat;
            idx_n     = IW'(PAT_W - 1);
            o_n.x     = load_pat[PAT_W-1];
            o_n.valid = 1'b1;
            o_n.sof   = 1'b1;
            o_n.busy  = 1'b1;
        end
    end

    assign bus.x     = o.x;
    assign bus.valid = o.valid;
    assign bus.sof   = o.sof;
    assign bus.eof   = o.eof;
    assign bus.busy  = o.busy;
    assign bus.done  = o.done;
endmodule
